// File: rtl/keypad_scan_pkg.sv
// Shared count_game definitions for the keypad scanner: FSM and frame-result encodings,
// plus the matrix geometry defaults shared with the dot-matrix row driver.
package keypad_scan_pkg;

    localparam int ROWS_DEF = 4;
    localparam int COLS_DEF = 4;
    localparam int SLOT_DEF = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAND    = 2'd1;
    localparam logic [1:0] ST_PRESSED = 2'd2;
    localparam logic [1:0] ST_REL     = 2'd3;

    localparam logic [1:0] RES_NONE  = 2'd0;
    localparam logic [1:0] RES_ONE   = 2'd1;
    localparam logic [1:0] RES_MULTI = 2'd2;

    // hits is a count of closed keys saturated at 2
    function automatic logic [1:0] frame_result(input logic [1:0] hits);
        if (hits == 2'd0)
            return RES_NONE;
        else if (hits == 2'd1)
            return RES_ONE;
        else
            return RES_MULTI;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the raw column lines; resets to all 1 (no key closed).
module keypad_col_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Row-scanning key matrix reader with frame-level debounce and a one-cycle press strobe.
// Optional auto-repeat while a key is held is enabled with `define KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int ROWS         = ROWS_DEF,
    parameter int COLS         = COLS_DEF,
    parameter int SLOT         = SLOT_DEF,
    parameter int DEB_SCANS    = 2,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8,
    localparam int CW          = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col,
    output logic [ROWS-1:0] row,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic [1:0]      dbg_state
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(SLOT);
    localparam int DW = $clog2(DEB_SCANS + 1);

    if (SLOT < 3 || DEB_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("keypad_scan: invalid parameter set");
    end

    logic            run;
    logic [SW-1:0]   slot_cnt;
    logic [RW-1:0]   row_idx;
    logic [COLS-1:0] col_s;
    logic            sample;
    logic            frame_end;

    logic [1:0]      acc_hits;
    logic [CW-1:0]   acc_code;
    logic [1:0]      row_hits;
    logic [CW-1:0]   row_code;
    logic [2:0]      hit_sum;
    logic [1:0]      fr_hits;
    logic [1:0]      fr_res;

    logic [1:0]      state;
    logic [1:0]      st_n;
    logic [CW-1:0]   cand;
    logic [CW-1:0]   cand_n;
    logic [DW-1:0]   deb_cnt;
    logic [DW-1:0]   deb_n;
    logic            accept;
    logic            drop;
    logic            rep_fire;

    keypad_col_sync #(.W(COLS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (col),
        .q   (col_s)
    );

    // run stays low for the reset cycle so the first cycle after reset drives row 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            run      <= 1'b0;
            slot_cnt <= '0;
            row_idx  <= '0;
        end else if (!run) begin
            run <= 1'b1;
        end else if (slot_cnt == SW'(SLOT - 1)) begin
            slot_cnt <= '0;
            row_idx  <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    always_comb begin
        row = '1;
        if (run)
            row[row_idx] = 1'b0;
    end

    assign sample    = run && (slot_cnt == SW'(SLOT - 1));
    assign frame_end = sample && (row_idx == RW'(ROWS - 1));

    // Merge this slot's sample with the frame so far; the last active bit wins the code.
    always_comb begin
        row_hits = 2'd0;
        row_code = acc_code;
        for (int c = 0; c < COLS; c++) begin
            if (!col_s[c]) begin
                if (row_hits != 2'd2)
                    row_hits = row_hits + 2'd1;
                row_code = CW'(int'(row_idx) * COLS + c);
            end
        end
        hit_sum = {1'b0, acc_hits} + {1'b0, row_hits};
        fr_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        fr_res  = frame_result(fr_hits);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_hits <= 2'd0;
            acc_code <= '0;
        end else if (frame_end) begin
            acc_hits <= 2'd0;
        end else if (sample) begin
            acc_hits <= fr_hits;
            acc_code <= row_code;
        end
    end

    always_comb begin
        st_n   = state;
        cand_n = cand;
        deb_n  = deb_cnt;
        accept = 1'b0;
        drop   = 1'b0;
        if (frame_end) begin
            case (state)
                ST_IDLE: begin
                    if (fr_res == RES_ONE) begin
                        cand_n = row_code;
                        deb_n  = DW'(1);
                        if (DEB_SCANS == 1) begin
                            accept = 1'b1;
                            st_n   = ST_PRESSED;
                        end else begin
                            st_n = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (fr_res == RES_ONE && row_code == cand) begin
                        deb_n = deb_cnt + DW'(1);
                        if (int'(deb_cnt) + 1 >= DEB_SCANS) begin
                            accept = 1'b1;
                            st_n   = ST_PRESSED;
                        end
                    end else begin
                        st_n = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (fr_res == RES_NONE) begin
                        deb_n = DW'(1);
                        if (DEB_SCANS == 1) begin
                            drop = 1'b1;
                            st_n = ST_IDLE;
                        end else begin
                            st_n = ST_REL;
                        end
                    end
                end
                default: begin
                    if (fr_res == RES_NONE) begin
                        deb_n = deb_cnt + DW'(1);
                        if (int'(deb_cnt) + 1 >= DEB_SCANS) begin
                            drop = 1'b1;
                            st_n = ST_IDLE;
                        end
                    end else begin
                        st_n = ST_PRESSED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cand      <= '0;
            deb_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= st_n;
            cand      <= cand_n;
            deb_cnt   <= deb_n;
            key_valid <= accept | rep_fire;
            if (accept) begin
                key_code <= row_code;
                key_held <= 1'b1;
            end else if (drop) begin
                key_held <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW  = $clog2(RMAX + 1);

    logic [RPW-1:0] rep_cnt;
    logic           rep_armed;
    logic           rep_step;

    // Only frames that start and stay in PRESSED advance the count; REL pauses it.
    assign rep_step = frame_end && (state == ST_PRESSED) && (st_n == ST_PRESSED);

    always_comb begin
        rep_fire = 1'b0;
        if (rep_step) begin
            if (!rep_armed)
                rep_fire = (int'(rep_cnt) + 1 == REPEAT_DELAY);
            else
                rep_fire = (int'(rep_cnt) + 1 == REPEAT_RATE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (accept || st_n == ST_IDLE) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (rep_step) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + RPW'(1);
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a key-matrix model answers the row drive,
// expected key codes are queued at stimulus time and popped on each key_valid strobe.
module tb_keypad_scan;

    localparam int ROWS = 4;
    localparam int COLS = 4;
`ifdef KEYPAD_REPEAT_EN
    localparam int N_REP = 5;
`else
    localparam int N_REP = 1;
`endif

    logic            clk;
    logic            rst;
    logic [COLS-1:0] col;
    logic [ROWS-1:0] row;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;
    logic [1:0]      dbg_state;

    logic [15:0]     keys_down;
    logic            ovr_en;
    logic [COLS-1:0] ovr_val;
    logic [COLS-1:0] col_model;

    logic [3:0]      exp_q[$];
    int              n_cmp;
    int              n_err;
    int              cyc;
    int              strobe_cnt;
    int              strobe_cyc;
    logic            bounce_win;
    logic            bounce_bad;

    keypad_scan #(
        .ROWS(4), .COLS(4), .SLOT(4), .DEB_SCANS(2), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // key matrix: a closed key pulls its column low while its row is driven low
    always_comb begin
        col_model = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row[r] && keys_down[r * COLS + c])
                    col_model[c] = 1'b0;
        col = ovr_en ? ovr_val : col_model;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every strobe must have a queued expectation with a matching code
    always @(negedge clk) begin
        if (rst && key_valid) begin
            strobe_cnt++;
            strobe_cyc = cyc;
            check_val("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check_val("key_code_strobe", 32'(key_code), 32'(exp_q.pop_front()));
        end
        if (bounce_win && dbg_state[1])
            bounce_bad = 1'b1;
    end

    task automatic wait_frame();
        logic [ROWS-1:0] prev;
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = row;
            @(posedge clk);
            #1;
            if (row == 4'b1110 && prev != 4'b1110)
                found = 1;
        end
        if (!found)
            check_val("frame_timeout", 32'(found), 32'd1);
    endtask

    task automatic wait_strobe(input int n_before, input int budget);
        for (int i = 0; i < budget && strobe_cnt == n_before; i++) begin
            @(posedge clk);
            #1;
        end
        check_val("strobe_seen", 32'(strobe_cnt > n_before), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst     = 1'b0;
        ovr_en  = 1'b1;
        ovr_val = 4'b1110;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_row", 32'(row), 32'hF);
            check_val("rst_held", 32'(key_held), 32'd0);
            check_val("rst_valid", 32'(key_valid), 32'd0);
            check_val("rst_code", 32'(key_code), 32'd0);
            check_val("rst_state", 32'(dbg_state), 32'd0);
        end
        rst       = 1'b1;
        ovr_en    = 1'b0;
        keys_down = '0;
        @(posedge clk);
        #1;
        check_val("first_row", 32'(row), 32'hE);
    endtask

    initial begin
        int n0;
        int c0;
        n_cmp      = 0;
        n_err      = 0;
        cyc        = 0;
        strobe_cnt = 0;
        strobe_cyc = 0;
        bounce_win = 1'b0;
        bounce_bad = 1'b0;
        keys_down  = '0;
        ovr_en     = 1'b1;
        ovr_val    = 4'b1110;
        rst        = 1'b0;

        // reset with a key pattern on the columns, then idle frames with no strobe
        do_reset(3);
        n0 = strobe_cnt;
        repeat (3) wait_frame();
        check_val("idle_no_strobe", 32'(strobe_cnt), 32'(n0));
        check_val("idle_held", 32'(key_held), 32'd0);

        // clean press of key 9 (row 2, col 1) from frame start
        wait_frame();
        c0 = cyc;
        n0 = strobe_cnt;
        keys_down[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_strobe(n0, 60);
        check_val("press_latency_ok", 32'((strobe_cyc - c0) <= 51), 32'd1);
        check_val("press_code", 32'(key_code), 32'd9);
        check_val("press_held", 32'(key_held), 32'd1);

        // release bounce: absent one frame, present one frame
        n0 = strobe_cnt;
        wait_frame();
        keys_down = '0;
        wait_frame();
        keys_down[9] = 1'b1;
        wait_frame();
        check_val("rel_bounce_held", 32'(key_held), 32'd1);
        keys_down = '0;
        repeat (3) wait_frame();
        check_val("release_held", 32'(key_held), 32'd0);
        check_val("release_code", 32'(key_code), 32'd9);
        check_val("release_no_strobe", 32'(strobe_cnt), 32'(n0));

        // press bounce: never reaches PRESSED
        n0 = strobe_cnt;
        bounce_win = 1'b1;
        for (int i = 0; i < 3; i++) begin
            keys_down[9] = 1'b1;
            wait_frame();
            keys_down = '0;
            wait_frame();
        end
        bounce_win = 1'b0;
        check_val("bounce_state_ok", 32'(bounce_bad), 32'd0);
        check_val("bounce_no_strobe", 32'(strobe_cnt), 32'(n0));
        check_val("bounce_idle", 32'(dbg_state), 32'd0);

        // chord of keys 0 and 5, then release key 5
        n0 = strobe_cnt;
        keys_down[0] = 1'b1;
        keys_down[5] = 1'b1;
        repeat (3) wait_frame();
        check_val("chord_no_strobe", 32'(strobe_cnt), 32'(n0));
        check_val("chord_idle", 32'(dbg_state), 32'd0);
        keys_down[5] = 1'b0;
        exp_q.push_back(4'd0);
        wait_strobe(n0, 60);
        check_val("chord_code", 32'(key_code), 32'd0);
        check_val("chord_held", 32'(key_held), 32'd1);
        keys_down = '0;
        repeat (4) wait_frame();
        check_val("chord_release_held", 32'(key_held), 32'd0);

        // hold key 15 through ten frames past acceptance
        wait_frame();
        n0 = strobe_cnt;
        keys_down[15] = 1'b1;
        for (int i = 0; i < N_REP; i++)
            exp_q.push_back(4'd15);
        repeat (12) wait_frame();
        keys_down = '0;
        repeat (4) wait_frame();
        check_val("hold_strobes", 32'(strobe_cnt - n0), 32'(N_REP));
        check_val("hold_code", 32'(key_code), 32'd15);
        check_val("hold_release_held", 32'(key_held), 32'd0);

        // reset in the middle of a press
        wait_frame();
        n0 = strobe_cnt;
        keys_down[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_strobe(n0, 60);
        repeat (5) @(posedge clk);
        #1;
        do_reset(3);
        n0 = strobe_cnt;
        repeat (4) wait_frame();
        check_val("post_rst_no_strobe", 32'(strobe_cnt), 32'(n0));
        check_val("post_rst_held", 32'(key_held), 32'd0);
        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
